// File: rtl/sram_controller.sv
// MEM-stage data memory front end: splits each 32-bit load/store into two
// halfword phases on a 16-bit asynchronous SRAM, holding `ready` low meanwhile.
module sram_controller #(
  parameter logic [31:0] BASE_ADDR   = 32'd1024,
  parameter int          SRAM_ADDR_W = 18,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rd_en,
  input  logic                   wr_en,
  input  logic [31:0]            address,
  input  logic [31:0]            write_data,
  output logic [31:0]            read_data,
  output logic                   ready,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [15:0]            sram_dq_out,
  output logic                   sram_dq_oe,
  input  logic [15:0]            sram_dq_in,
  output logic                   sram_we_n
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOW  = 2'd1;
  localparam logic [1:0] HIGH = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam int             CNT_W    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  logic [1:0]             state;
  logic [CNT_W-1:0]       count;
  logic                   is_write;
  logic [15:0]            low_hold;
  logic [31:0]            offset;
  logic [SRAM_ADDR_W-2:0] idx;
  logic                   phase_last;
  logic                   unused_offset;

  // Word index relative to the base; the subtraction wraps so addresses below
  // BASE_ADDR land at the top of the SRAM.
  assign offset        = address - BASE_ADDR;
  assign idx           = offset[SRAM_ADDR_W:2];
  assign unused_offset = ^{offset[31:SRAM_ADDR_W+1], offset[1:0]};
  assign phase_last    = (count == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      is_write  <= 1'b0;
      read_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          count <= '0;
          if (rd_en || wr_en) begin
            state    <= LOW;
            is_write <= wr_en;
          end
        end
        LOW: begin
          if (phase_last) begin
            state <= HIGH;
            count <= '0;
          end else begin
            count <= count + CNT_W'(1);
          end
        end
        HIGH: begin
          if (phase_last) begin
            state <= DONE;
            count <= '0;
            if (!is_write) read_data <= {sram_dq_in, low_hold};
          end else begin
            count <= count + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          count <= '0;
        end
      endcase
    end
  end

  // Low halfword is sampled at the end of its phase, after the full wait time.
  always_ff @(posedge clk) begin
    if (state == LOW && phase_last && !is_write) low_hold <= sram_dq_in;
  end

  always_comb begin
    ready = (state == DONE) || (state == IDLE && !rd_en && !wr_en);
  end

  always_comb begin
    sram_addr   = '0;
    sram_dq_out = '0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;
    if (state == LOW || state == HIGH) begin
      sram_addr = {idx, (state == HIGH)};
      if (is_write) begin
        sram_dq_out = (state == HIGH) ? write_data[31:16] : write_data[15:0];
        sram_dq_oe  = 1'b1;
        sram_we_n   = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// Scoreboard bench for sram_controller against a behavioural 16-bit SRAM.
module tb_sram_controller;

  localparam int W  = 2;
  localparam int AW = 18;

  logic          clk = 1'b0;
  logic          rst;
  logic          rd_en, wr_en;
  logic [31:0]   address, write_data;
  logic [31:0]   read_data;
  logic          ready;
  logic [AW-1:0] sram_addr;
  logic [15:0]   sram_dq_out;
  logic          sram_dq_oe;
  logic [15:0]   sram_dq_in;
  logic          sram_we_n;

  sram_controller #(.BASE_ADDR(32'd1024), .SRAM_ADDR_W(AW), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .address(address),
    .write_data(write_data), .read_data(read_data), .ready(ready),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
    .sram_dq_in(sram_dq_in), .sram_we_n(sram_we_n)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural asynchronous SRAM, with a preload port for the bench.
  logic [15:0]   sram_mem [0:(1<<AW)-1];
  logic          pre_en = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [15:0]   pre_data = '0;
  always @(posedge clk) begin
    if (pre_en) sram_mem[pre_addr] <= pre_data;
    else if (sram_we_n === 1'b0) sram_mem[sram_addr] <= sram_dq_out;
  end
  assign sram_dq_in = sram_mem[sram_addr];

  int checks = 0;
  int failures = 0;
  logic [31:0] model [int];
  logic [31:0] exp_q [$];
  logic [31:0] last_read = '0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [AW-1:0] half_addr(input logic [31:0] a, input logic hi);
    logic [31:0] off;
    off = a - 32'd1024;
    return {off[AW:2], hi};
  endfunction

  task automatic preload(input logic [AW-1:0] a, input logic [15:0] d);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    @(posedge clk); #1;
    pre_en = 1'b0;
  endtask

  // Drives one request from the IDLE decode cycle through DONE, checking the
  // bus every cycle and popping the scoreboard when a load completes.
  task automatic run_access(input logic rd, input logic wr, input logic [31:0] addr,
                            input logic [31:0] data);
    int done_cyc;
    logic in_low, in_high, act;
    logic [31:0] exp;
    rd_en = rd; wr_en = wr; address = addr; write_data = data;
    if (wr) model[addr] = data;
    else if (rd) exp_q.push_back(model[addr]);
    done_cyc = -1;
    for (int c = 0; c <= 2*W + 4; c++) begin
      @(negedge clk);
      in_low  = (c >= 1) && (c <= W);
      in_high = (c > W) && (c <= 2*W);
      act     = in_low || in_high;
      check_val("ready", {31'd0, ready}, {31'd0, (c == 2*W + 1)});
      check_val("sram_addr", 32'(sram_addr), act ? 32'(half_addr(addr, in_high)) : 32'd0);
      check_val("sram_we_n", {31'd0, sram_we_n}, {31'd0, !(wr && act)});
      check_val("sram_dq_oe", {31'd0, sram_dq_oe}, {31'd0, (wr && act)});
      check_val("sram_dq_out", {16'd0, sram_dq_out},
                (wr && act) ? {16'd0, (in_high ? data[31:16] : data[15:0])} : 32'd0);
      if (ready) begin
        done_cyc = c;
        if (rd && !wr) begin
          if (exp_q.size() == 0) begin
            check_val("scoreboard_empty", 32'd1, 32'd0);
          end else begin
            exp = exp_q.pop_front();
            check_val("read_data", read_data, exp);
            last_read = exp;
          end
        end else begin
          check_val("read_data_unchanged", read_data, last_read);
        end
      end
      @(posedge clk); #1;
      if (done_cyc >= 0) break;
    end
    rd_en = 1'b0; wr_en = 1'b0;
    check_val("done_cycle", 32'(done_cyc), 32'(2*W + 1));
  endtask

  int start;
  logic [31:0] ra, rdat;

  initial begin
    rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; address = '0; write_data = '0;
    for (int i = 0; i < (1 << AW); i++) sram_mem[i] = 16'h0000;
    preload(AW'(2), 16'hF00D);
    preload(AW'(3), 16'hCAFE);
    model[1028] = 32'hCAFEF00D;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check_val("rst_read_data", read_data, 32'd0);
    check_val("rst_ready", {31'd0, ready}, 32'd1);
    check_val("rst_we_n", {31'd0, sram_we_n}, 32'd1);
    check_val("rst_oe", {31'd0, sram_dq_oe}, 32'd0);
    check_val("rst_addr", 32'(sram_addr), 32'd0);
    check_val("rst_dq_out", {16'd0, sram_dq_out}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Store then load at 1032; halves must land at SRAM 4 and 5.
    run_access(1'b0, 1'b1, 32'd1032, 32'hDEADBEEF);
    check_val("mem_lo_4", {16'd0, sram_mem[4]}, 32'h0000BEEF);
    check_val("mem_hi_5", {16'd0, sram_mem[5]}, 32'h0000DEAD);
    run_access(1'b1, 1'b0, 32'd1032, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    check_val("read_hold", read_data, 32'hDEADBEEF);

    // Back-to-back store/load with no idle gap.
    start = cyc;
    run_access(1'b0, 1'b1, 32'd1024, 32'h12345678);
    run_access(1'b1, 1'b0, 32'd1024, 32'h0);
    check_val("b2b_cycles", 32'(cyc - start), 32'd12);

    // Reset in the middle of a write to 1036.
    rd_en = 1'b0; wr_en = 1'b1; address = 32'd1036; write_data = 32'h11112222;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1; wr_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_val("midrst_we_n", {31'd0, sram_we_n}, 32'd1);
    check_val("midrst_oe", {31'd0, sram_dq_oe}, 32'd0);
    check_val("midrst_read_data", read_data, 32'd0);
    check_val("midrst_ready", {31'd0, ready}, 32'd1);
    check_val("midrst_addr", 32'(sram_addr), 32'd0);
    last_read = 32'd0;
    @(posedge clk); #1;
    run_access(1'b1, 1'b0, 32'd1028, 32'h0);

    // Both requests: write wins, at the wrapped top of the SRAM.
    rd_en = 1'b1; wr_en = 1'b1; address = 32'd1020; write_data = 32'hA5A55A5A;
    model[1020] = 32'hA5A55A5A;
    @(posedge clk); #1;
    @(negedge clk);
    check_val("wrap_lo_addr", 32'(sram_addr), 32'h3FFFE);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check_val("wrap_hi_addr", 32'(sram_addr), 32'h3FFFF);
    check_val("wrap_we_n", {31'd0, sram_we_n}, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check_val("wrap_ready", {31'd0, ready}, 32'd1);
    check_val("wrap_read_data_kept", read_data, 32'hCAFEF00D);
    @(posedge clk); #1;
    rd_en = 1'b0; wr_en = 1'b0;
    run_access(1'b1, 1'b1, 32'd1020, 32'h0F0F0F0F);
    model[1020] = 32'h0F0F0F0F;
    run_access(1'b1, 1'b0, 32'd1020, 32'h0);

    // A few random store/load pairs.
    for (int i = 0; i < 4; i++) begin
      ra   = 32'd1024 + 32'(4 * $urandom_range(8, 15));
      rdat = $urandom;
      run_access(1'b0, 1'b1, ra, rdat);
      run_access(1'b1, 1'b0, ra, 32'h0);
    end

    check_val("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
